shift_xfer_ctrl: RTL

//  Transfer controller for an external SIZE-stage serial shift register (SI->SO delay line).
//  - Accepts a parallel word over a valid/ready handshake and drives it LSB-first onto the register's SI.
//  - Samples SO SIZE cycles later and reassembles the word.
//  - Presents the reassembled word on a valid/ready output.
//  - Sits between a parallel producer/consumer and the shift_reg datapath; one transfer in flight at a time.

---
 rtl/shift_xfer_pkg.sv | 17 +
 rtl/shift_xfer_cnt.sv | 39 +++
 rtl/shift_xfer_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/shift_xfer_pkg.sv
// Shared types and helpers for the shift-register transfer controller.
//   state_t   : 2-bit FSM encoding (IDLE, FEED, DONE)
//   cnt_width : bit width of the per-transfer cycle counter
package shift_xfer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t FEED = 2'd1;
  localparam state_t DONE = 2'd2;

  // Counter must hold 0..size+width without wrapping.
  function automatic int unsigned cnt_width(input int unsigned size, input int unsigned width);
    return $clog2(size + width + 1);
  endfunction

endpackage

// File: rtl/shift_xfer_cnt.sv
// Transfer cycle counter.
//   clk, rstn : clock, async active-low reset
//   clr       : restart at 0 (priority over en)
//   en        : advance one step per cycle, saturating at the last value
//   cap_en    : cyc >= SIZE (SO now carries word bits)
//   last      : cyc == SIZE+WIDTH-1 (final cycle of the transfer)
module shift_xfer_cnt
  import shift_xfer_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic cap_en,
  output logic last
);

  localparam int unsigned CW = cnt_width(SIZE, WIDTH);

  logic [CW-1:0] cyc;

  // Counter holds at the last value so it never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc <= '0;
    end else if (clr) begin
      cyc <= '0;
    end else if (en && !last) begin
      cyc <= cyc + CW'(1);
    end
  end

  assign cap_en = (cyc >= CW'(SIZE));
  assign last   = (cyc == CW'(SIZE + WIDTH - 1));

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Transfer controller for an external SIZE-stage SI->SO shift register.
// Takes a parallel word, streams it LSB-first on sr_si, captures it back
// from sr_so SIZE cycles later, and presents the reassembled word.
//   clk, rstn            : clock, async active-low reset
//   in_valid/in_ready    : input handshake (in_ready combinational, high in IDLE)
//   in_data              : word to transfer
//   sr_si / sr_so        : serial out to / serial in from the shift register
//   out_valid/out_ready  : output handshake; out_data held while stalled
//   busy                 : transfer in FEED or DONE
//   err_mismatch         : sticky loopback mismatch flag
// Optional build macro SHIFT_XFER_CHECK_EN enables the mismatch checker;
// without it err_mismatch is tied low.
module shift_xfer_ctrl
  import shift_xfer_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_si,
  input  logic             sr_so,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err_mismatch
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             sr_si_q, sr_si_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             cap_en;
  logic             last;
  logic [WIDTH-1:0] rx_shift;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  shift_xfer_cnt #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (accept),
    .en     (state_q == FEED),
    .cap_en (cap_en),
    .last   (last)
  );

  // Incoming SO bit enters at the MSB so the first captured bit ends at bit 0.
  generate
    if (WIDTH == 1) begin : g_rx1
      assign rx_shift = sr_so;
    end else begin : g_rxn
      assign rx_shift = {sr_so, rx_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    out_data_d  = out_data_q;
    sr_si_d     = sr_si_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FEED;
          tx_d    = in_data >> 1;
          sr_si_d = in_data[0];
          rx_d    = '0;
          busy_d  = 1'b1;
        end
      end
      FEED: begin
        // tx shifts in zeros, so once the word is out sr_si flushes with 0.
        sr_si_d = tx_q[0];
        tx_d    = tx_q >> 1;
        if (cap_en) begin
          rx_d = rx_shift;
        end
        if (last) begin
          state_d     = DONE;
          out_data_d  = rx_shift;
          out_valid_d = 1'b1;
          sr_si_d     = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      out_data_q  <= '0;
      sr_si_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      out_data_q  <= out_data_d;
      sr_si_q     <= sr_si_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sr_si     = sr_si_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef SHIFT_XFER_CHECK_EN
  logic [WIDTH-1:0] shadow_q;
  logic             err_q;

  // Compare the returned word against the accepted one on entry to DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q <= in_data;
      end
      if ((state_q == FEED) && last && (rx_shift != shadow_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_mismatch = err_q;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule
